// File: rtl/io_responder_if.sv
// Processor data-bus view of the I/O responder: address/data/strobe from the
// processor, registered read data and hit flag back from the responder.
interface io_responder_if;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] ReadData;
    logic        Hit;

    modport master (output ADDR, DOUT, W, input  ReadData, Hit);
    modport slave  (input  ADDR, DOUT, W, output ReadData, Hit);
endinterface

// File: rtl/io_responder.sv
// Memory-mapped I/O responder: one 8-word window holding a paced LED FIFO,
// a STATUS word, sampled switches and a HEX register. Reads have one cycle of
// latency, matching the synchronous data RAM.
// Optional feature macro: IO_RESPONDER_IRQ_EN adds a registered Irq output.
module io_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          PACE_CYCLES = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    io_responder_if.slave bus,
    input  logic [15:0]   Switches,
    output logic [15:0]   LedOut,
`ifdef IO_RESPONDER_IRQ_EN
    output logic [15:0]   HexOut,
    output logic          Irq
`else
    output logic [15:0]   HexOut
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
    localparam logic [4:0]    DEPTH_C   = 5'(FIFO_DEPTH);
    localparam logic [CW-1:0] PACE_LAST = CW'(PACE_CYCLES - 1);

    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [4:0]    count;
    logic [CW-1:0] pace;
    logic          ovf, swchg;
    logic [15:0]   sw_reg;

    logic        sel, is_rd, full, pop, push_req, push_ok, ovf_set;
    logic        st_wr, sw_rd, sw_chg;
    logic [2:0]  off;
    logic [15:0] rd_mux;

    // Address decode and FIFO/flag control; pop is decided before push so a
    // full FIFO still accepts a push on a pop cycle.
    always_comb begin
        sel      = (bus.ADDR[15:3] == BASE_ADDR[15:3]);
        off      = bus.ADDR[2:0];
        is_rd    = sel & ~bus.W;
        full     = (count == DEPTH_C);
        pop      = (pace == PACE_LAST) && (count != 5'd0);
        push_req = sel & bus.W & (off == 3'd0);
        push_ok  = push_req & (pop | ~full);
        ovf_set  = push_req & ~pop & full;
        st_wr    = sel & bus.W & (off == 3'd1);
        sw_rd    = is_rd & (off == 3'd2);
        sw_chg   = (Switches != sw_reg);
    end

    // Read mux over the pre-edge state of the window registers.
    always_comb begin
        rd_mux = 16'h0000;
        case (off)
            3'd0: rd_mux = (count != 5'd0) ? mem[rptr] : 16'h0000;
            3'd1: rd_mux = {8'h00, count, ovf, full, swchg};
            3'd2: rd_mux = sw_reg;
            3'd3: rd_mux = HexOut;
            default: rd_mux = 16'h0000;
        endcase
    end

    // FIFO storage; no reset needed since empty reads are masked to zero.
    always_ff @(posedge Clock) begin
        if (push_ok) mem[wptr] <= bus.DOUT;
    end

    // FIFO pointers, occupancy, pace counter and LED output register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= 5'd0;
            pace   <= '0;
            LedOut <= 16'h0000;
        end else begin
            pace <= (pace == PACE_LAST) ? '0 : pace + CW'(1);
            if (push_ok) wptr <= wptr + PW'(1);
            if (pop) begin
                rptr   <= rptr + PW'(1);
                LedOut <= mem[rptr];
            end
            count <= count + 5'(push_ok) - 5'(pop);
        end
    end

    // Sticky flags: a new event always beats a simultaneous clear.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ovf    <= 1'b0;
            swchg  <= 1'b0;
            sw_reg <= 16'h0000;
        end else begin
            if (ovf_set)    ovf <= 1'b1;
            else if (st_wr) ovf <= 1'b0;
            if (sw_chg)     swchg <= 1'b1;
            else if (sw_rd) swchg <= 1'b0;
            sw_reg <= Switches;
        end
    end

    // Bus response, HEX register; ReadData only reloads on in-window reads.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            bus.ReadData <= 16'h0000;
            bus.Hit      <= 1'b0;
            HexOut       <= 16'h0000;
        end else begin
            bus.Hit <= sel;
            if (is_rd) bus.ReadData <= rd_mux;
            if (sel && bus.W && off == 3'd3) HexOut <= bus.DOUT;
        end
    end

`ifdef IO_RESPONDER_IRQ_EN
    // Interrupt follows the flags one cycle later.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) Irq <= 1'b0;
        else       Irq <= swchg | ovf;
    end
`endif
endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: a constant vector table, hand-built
// corner sequences and random traffic, all compared against a queue-based
// reference model of the register window.
module tb_io_responder;
    localparam logic [15:0] BASE  = 16'hFF00;
    localparam int          DEPTH = 4;
    localparam int          PACE  = 8;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Switches = 16'h0000;
    logic [15:0] LedOut, HexOut;
`ifdef IO_RESPONDER_IRQ_EN
    logic        Irq;
`endif
    io_responder_if bus();

    io_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .PACE_CYCLES(PACE)) dut (
        .Clock(Clock), .Reset(Reset), .bus(bus), .Switches(Switches),
`ifdef IO_RESPONDER_IRQ_EN
        .Irq(Irq),
`endif
        .LedOut(LedOut), .HexOut(HexOut)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          t;
    logic [15:0] q[$];
    logic [15:0] m_rd, m_led, m_hex, m_swreg, cur_sw;
    logic        m_hit, m_ovf, m_swchg, m_irq;

    typedef struct {
        logic        w;
        logic [15:0] addr, dout, rd;
        logic        hit;
        logic [15:0] hex;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic model_reset();
        q.delete();
        t = 0;
        m_rd = 0; m_led = 0; m_hex = 0; m_swreg = 0;
        m_hit = 0; m_ovf = 0; m_swchg = 0; m_irq = 0;
    endtask

    // One clock edge of the register window, from the behavioural rules.
    task automatic model_edge(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] sw);
        logic sel, ovfset;
        logic [2:0] off;
        logic [15:0] rdv;
        sel = (a[15:3] == BASE[15:3]);
        off = a[2:0];
        m_irq = m_swchg | m_ovf;
        case (off)
            3'd0: rdv = (q.size() > 0) ? q[0] : 16'h0000;
            3'd1: rdv = {8'h00, 5'(q.size()), m_ovf, (q.size() == DEPTH), m_swchg};
            3'd2: rdv = m_swreg;
            3'd3: rdv = m_hex;
            default: rdv = 16'h0000;
        endcase
        if ((t % PACE) == PACE - 1 && q.size() > 0) m_led = q.pop_front();
        ovfset = 1'b0;
        if (w && sel && off == 3'd0) begin
            if (q.size() < DEPTH) q.push_back(d);
            else ovfset = 1'b1;
        end
        if (ovfset) m_ovf = 1'b1;
        else if (w && sel && off == 3'd1) m_ovf = 1'b0;
        if (sw != m_swreg) m_swchg = 1'b1;
        else if (!w && sel && off == 3'd2) m_swchg = 1'b0;
        m_swreg = sw;
        if (w && sel && off == 3'd3) m_hex = d;
        if (sel && !w) m_rd = rdv;
        m_hit = sel;
        t++;
    endtask

    task automatic compare_all();
        check("rd", bus.ReadData, m_rd);
        check("hit", 16'(bus.Hit), 16'(m_hit));
        check("led", LedOut, m_led);
        check("hex", HexOut, m_hex);
`ifdef IO_RESPONDER_IRQ_EN
        check("irq", 16'(Irq), 16'(m_irq));
`endif
    endtask

    // Apply one bus access for one cycle; called and returns at a negedge.
    task automatic step(input logic w, input logic [15:0] a, input logic [15:0] d);
        bus.W = w; bus.ADDR = a; bus.DOUT = d; Switches = cur_sw;
        @(posedge Clock);
        model_edge(w, a, d, cur_sw);
        @(negedge Clock);
        compare_all();
    endtask

    task automatic idle_until(input int target);
        for (int i = 0; i < 200 && t < target; i++) step(1'b0, 16'h0000, 16'h0000);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        bus.W = 1'b0; bus.ADDR = 16'h0000; bus.DOUT = 16'h0000;
        #2 Reset = 1'b1;
        #1;
        check("rst_rd", bus.ReadData, 16'h0000);
        check("rst_hit", 16'(bus.Hit), 16'h0000);
        check("rst_led", LedOut, 16'h0000);
        check("rst_hex", HexOut, 16'h0000);
        model_reset();
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 16'hFF03, 16'h1234, 16'h0000, 1'b1, 16'h1234};
        tbl[1]  = '{1'b0, 16'hFF03, 16'h0000, 16'h1234, 1'b1, 16'h1234};
        tbl[2]  = '{1'b0, 16'hFF10, 16'h0000, 16'h1234, 1'b0, 16'h1234};
        tbl[3]  = '{1'b0, 16'hFF04, 16'h0000, 16'h0000, 1'b1, 16'h1234};
        tbl[4]  = '{1'b1, 16'hFF05, 16'hFFFF, 16'h0000, 1'b1, 16'h1234};
        tbl[5]  = '{1'b0, 16'hFF07, 16'h0000, 16'h0000, 1'b1, 16'h1234};
        tbl[6]  = '{1'b0, 16'hFF01, 16'h0000, 16'h0000, 1'b1, 16'h1234};
        tbl[7]  = '{1'b1, 16'hFF03, 16'hBEEF, 16'h0000, 1'b1, 16'hBEEF};
        tbl[8]  = '{1'b0, 16'hFF03, 16'h0000, 16'hBEEF, 1'b1, 16'hBEEF};
        tbl[9]  = '{1'b0, 16'hFEFB, 16'h0000, 16'hBEEF, 1'b0, 16'hBEEF};
        tbl[10] = '{1'b0, 16'hFF00, 16'h0000, 16'h0000, 1'b1, 16'hBEEF};
        tbl[11] = '{1'b1, 16'hFF02, 16'h1111, 16'h0000, 1'b1, 16'hBEEF};
        tbl[12] = '{1'b0, 16'hFF02, 16'h0000, 16'h0000, 1'b1, 16'hBEEF};
        tbl[13] = '{1'b0, 16'hFF0B, 16'h0000, 16'h0000, 1'b0, 16'hBEEF};

        cur_sw = 16'h0000;
        bus.W = 1'b0; bus.ADDR = 16'h0000; bus.DOUT = 16'h0000;
        model_reset();
        repeat (2) @(negedge Clock);
        Reset = 1'b0;

        // Reset in the middle of a drain with entries still queued
        step(1'b1, 16'hFF00, 16'h0011);
        step(1'b1, 16'hFF00, 16'h0022);
        step(1'b1, 16'hFF00, 16'h0033);
        step(1'b1, 16'hFF03, 16'h5555);
        idle_until(9);
        check("drain_led", LedOut, 16'h0011);
        do_reset();
        step(1'b0, 16'hFF01, 16'h0000);
        check("rst_status", bus.ReadData, 16'h0000);

        // Constant vectors: HEX, holding ReadData, out-of-window and unused offsets
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].w, tbl[i].addr, tbl[i].dout);
            check($sformatf("vec%0d_rd", i), bus.ReadData, tbl[i].rd);
            check($sformatf("vec%0d_hit", i), 16'(bus.Hit), 16'(tbl[i].hit));
            check($sformatf("vec%0d_hex", i), HexOut, tbl[i].hex);
        end

        // Five pushes into a 4-deep FIFO: last one dropped, then paced drain
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 16'hFF00, 16'(i));
        step(1'b0, 16'hFF01, 16'h0000);
        check("ovf_status", bus.ReadData, 16'h0026);
        for (int i = 1; i <= 4; i++) begin
            idle_until(PACE * i);
            check($sformatf("drain%0d_led", i), LedOut, 16'(i));
        end
        idle_until(PACE * 5 + 2);
        check("drain_end_led", LedOut, 16'h0004);

        // Full FIFO with a push landing on the pop cycle
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 16'hFF00, 16'(16'h0010 + i));
        idle_until(PACE - 1);
        step(1'b1, 16'hFF00, 16'h0099);
        check("fullpop_led", LedOut, 16'h0011);
        step(1'b0, 16'hFF01, 16'h0000);
        check("fullpop_status", bus.ReadData, 16'h0022);

        // Switch change flag, clear-on-read, and change winning over the clear
        do_reset();
        cur_sw = 16'h00A5;
        step(1'b0, 16'hFF10, 16'h0000);
        step(1'b0, 16'hFF01, 16'h0000);
        check("swchg_set", bus.ReadData, 16'h0001);
        step(1'b0, 16'hFF02, 16'h0000);
        check("sw_read", bus.ReadData, 16'h00A5);
        step(1'b0, 16'hFF01, 16'h0000);
        check("swchg_clr", bus.ReadData, 16'h0000);
        cur_sw = 16'h005A;
        step(1'b0, 16'hFF02, 16'h0000);
        check("sw_read2", bus.ReadData, 16'h00A5);
        step(1'b0, 16'hFF01, 16'h0000);
        check("swchg_keep", bus.ReadData, 16'h0001);

        // Overflow flag and its clear by a STATUS write
        do_reset();
        cur_sw = 16'h0000;
        for (int i = 1; i <= 5; i++) step(1'b1, 16'hFF00, 16'(i));
`ifdef IO_RESPONDER_IRQ_EN
        step(1'b1, 16'hFF01, 16'hFFFF);
        check("irq_high", 16'(Irq), 16'h0001);
        step(1'b0, 16'hFF01, 16'h0000);
        check("irq_low", 16'(Irq), 16'h0000);
`else
        step(1'b1, 16'hFF01, 16'hFFFF);
        step(1'b0, 16'hFF01, 16'h0000);
`endif
        check("ovf_clr_status", bus.ReadData, 16'h0022);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r;
            logic w;
            logic [15:0] a;
            r = int'($urandom_range(0, 9));
            if (r < 8)       a = BASE + 16'(r);
            else if (r == 8) a = 16'hFF10;
            else             a = 16'($urandom);
            w = ($urandom_range(0, 2) == 0) || (r == 0 && $urandom_range(0, 1) == 0);
            if ($urandom_range(0, 7) == 0) cur_sw = 16'($urandom_range(0, 3));
            step(w, a, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
